// File: rtl/pattern_gen.sv
// Multi-channel test-signal generator: prescaled up/down/LFSR/walking-one channels with a valid/ready load port.
// Optional feature macro: PATTERN_GEN_LFSR_EN builds the LFSR mode; without it mode 10 counts up.
module pattern_gen #(
  parameter int              WIDTH    = 8,
  parameter int              CHANNELS = 4,
  parameter int              DIV_W    = 16,
  parameter logic [WIDTH-1:0] TAPS    = 8'hB8,
  localparam int             LCW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [DIV_W-1:0]          div,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [LCW-1:0]            load_chan,
  input  logic [WIDTH-1:0]          load_data,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic                      tick,
  output logic [CHANNELS-1:0]       wrap
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0]          pcnt_q, pcnt_d;
  logic [CHANNELS*WIDTH-1:0] chan_q, chan_d;
  logic [CHANNELS-1:0]       wrap_q, wrap_d;
  logic                      tick_q, tick_d;
  logic                      ready_q, ready_d;
  logic                      strobe;
  logic                      load_fire;

`ifndef PATTERN_GEN_LFSR_EN
  logic unused_taps;
  assign unused_taps = ^TAPS;
`endif

  // Returns {wrap_flag, next_value} for one channel step in the given mode.
  function automatic logic [WIDTH:0] advance(input logic [WIDTH-1:0] v, input logic [1:0] m);
    logic [WIDTH-1:0] nv;
    logic             w;
    logic             onehot;
    nv     = v;
    w      = 1'b0;
    onehot = (v != '0) && ((v & (v - ONE)) == '0);
    case (m)
      2'b01: begin
        nv = v - ONE;
        w  = (v == '0);
      end
`ifdef PATTERN_GEN_LFSR_EN
      2'b10: begin
        nv = (v == '0) ? ONE : ((v >> 1) ^ (v[0] ? TAPS : '0));
        w  = (nv == ONE);
      end
`endif
      2'b11: begin
        nv = onehot ? {v[WIDTH-2:0], v[WIDTH-1]} : ONE;
        w  = onehot & v[WIDTH-1];
      end
      default: begin
        nv = v + ONE;
        w  = &v;
      end
    endcase
    return {w, nv};
  endfunction

  // Handshake: a transfer happens on any edge with load_valid && load_ready;
  // load_ready then drops for exactly one cycle before accepting again.
  assign strobe    = en && (pcnt_q >= div);
  assign load_fire = load_valid && ready_q;

  always_comb begin
    logic [WIDTH:0] step;
    logic           hit;
    pcnt_d  = pcnt_q;
    chan_d  = chan_q;
    wrap_d  = '0;
    tick_d  = strobe;
    ready_d = !load_fire;
    step    = '0;
    hit     = 1'b0;
    if (en) pcnt_d = strobe ? '0 : pcnt_q + 1'b1;
    for (int k = 0; k < CHANNELS; k++) begin
      step = advance(chan_q[k*WIDTH +: WIDTH], mode);
      hit  = load_fire && (load_chan == LCW'(k));
      if (hit) begin
        chan_d[k*WIDTH +: WIDTH] = load_data;
      end else if (strobe) begin
        chan_d[k*WIDTH +: WIDTH] = step[WIDTH-1:0];
        wrap_d[k]                = step[WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q  <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= '0;
      ready_q <= 1'b1;
      for (int k = 0; k < CHANNELS; k++) chan_q[k*WIDTH +: WIDTH] <= WIDTH'(k);
    end else begin
      pcnt_q  <= pcnt_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      ready_q <= ready_d;
      chan_q  <= chan_d;
    end
  end

  assign out        = chan_q;
  assign tick       = tick_q;
  assign wrap       = wrap_q;
  assign load_ready = ready_q;

endmodule
